mux8_rr_arbiter: RTL

- Round-robin arbiter that shares the 8-to-1 data multiplexer between 8 requesters.
- Drives the mux select and enable from registered state, so the mux output is owned by exactly one requester at a time.
- Grants are held while the owner keeps its request high, with fair rotation on release.
- Sits directly in front of the mux8to1 datapath instance.

---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/mux8_rr_arbiter_if.sv | 28 ++
 rtl/mux8_rr_arbiter_rr_pick.sv | 24 ++
 rtl/mux8to1.sv | 12 +
 rtl/mux8_rr_arbiter.sv | 103 ++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the 8-way round-robin mux arbiter.
// Timeout option: MUX_ARB_TIMEOUT_EN (see mux8_rr_arbiter).
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_REQ-1:0] onehot(sel_t s);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface mux8_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  sel_t             sel;
  logic             en;
  logic             busy;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  en,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output en,
    output busy
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit at ptr, ptr+1, ... (mod 8).
// Purely combinational.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output sel_t             pick,
  output logic             valid
);

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + sel_t'(k)]) begin
        pick  = ptr + sel_t'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8to1.sv
// 8-to-1 bit multiplexer with enable; output forced low when disabled.
// Datapath shared by the arbiter's requesters.
module mux8to1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  input  logic       en,
  output logic       y
);

  assign y = en ? d[sel] : 1'b0;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the mux8to1 select/enable, registered outputs.
// Define MUX_ARB_TIMEOUT_EN to cap each grant at MAX_HOLD cycles.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
`ifdef MUX_ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 16
)
`endif
(
  input logic              clk,
  input logic              rst_n,
  mux8_rr_arbiter_if.slave bus
);

  arb_state_t       state, state_n;
  sel_t             ptr, ptr_n;
  sel_t             sel_q, sel_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic             en_q, en_n;
  sel_t             pick;
  logic             valid;
  logic             rel;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .pick  (pick),
    .valid (valid)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rel     = !bus.req[sel_q] || timeout;

  // Counts cycles spent in the current grant; zero on entry.
  always_comb begin
    cnt_n = '0;
    if (state == GRANT && state_n == GRANT)
      cnt_n = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_n;
  end
`else
  assign rel = !bus.req[sel_q];
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel_q;
    gnt_n   = gnt_q;
    en_n    = en_q;
    unique case (state)
      IDLE: begin
        if (valid) begin
          state_n = GRANT;
          sel_n   = pick;
          gnt_n   = onehot(pick);
          en_n    = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          state_n = IDLE;
          gnt_n   = '0;
          en_n    = 1'b0;
          ptr_n   = sel_q + sel_t'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel_q <= '0;
      gnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel_q <= sel_n;
      gnt_q <= gnt_n;
      en_q  <= en_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.busy = (state == GRANT);

endmodule
